// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcode encodings, FSM state encoding,
// the opcode-to-flag-write mask and the latency classes.
package alu_pkg;

  localparam logic [4:0] ALU_NOP    = 5'h00;
  localparam logic [4:0] ALU_ADD    = 5'h01;
  localparam logic [4:0] ALU_ADDC   = 5'h02;
  localparam logic [4:0] ALU_SUBB   = 5'h03;
  localparam logic [4:0] ALU_INC    = 5'h04;
  localparam logic [4:0] ALU_DEC    = 5'h05;
  localparam logic [4:0] ALU_MUL    = 5'h06;
  localparam logic [4:0] ALU_DIV    = 5'h07;
  localparam logic [4:0] ALU_DA     = 5'h08;
  localparam logic [4:0] ALU_AND    = 5'h09;
  localparam logic [4:0] ALU_OR     = 5'h0A;
  localparam logic [4:0] ALU_XOR    = 5'h0B;
  localparam logic [4:0] ALU_CLR_C  = 5'h0C;
  localparam logic [4:0] ALU_SETB_C = 5'h0D;
  localparam logic [4:0] ALU_CPL_C  = 5'h0E;
  localparam logic [4:0] ALU_ANL_C  = 5'h0F;
  localparam logic [4:0] ALU_ORL_C  = 5'h10;
  localparam logic [4:0] ALU_MOV_C  = 5'h11;

  // Opcodes at or above this value are rejected with an error response.
  localparam logic [4:0] ALU_OP_LIMIT = 5'h12;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    LAT_BASE,
    LAT_MUL,
    LAT_DIV
  } lat_class_e;

  typedef struct packed {
    logic cy_we;
    logic ac_we;
    logic ov_we;
  } flag_we_t;

  function automatic flag_we_t flag_mask(input logic [4:0] op);
    flag_we_t m;
    m = '0;
    if (op >= ALU_ADD && op <= ALU_SUBB) begin
      m.cy_we = 1'b1;
      m.ac_we = 1'b1;
      m.ov_we = 1'b1;
    end else if (op == ALU_MUL || op == ALU_DIV) begin
      m.cy_we = 1'b1;
      m.ov_we = 1'b1;
    end else if (op == ALU_DA || (op >= ALU_CLR_C && op <= ALU_MOV_C)) begin
      m.cy_we = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/alu_flag_mask.sv
// Combinational opcode decode: which PSW flags the ALU result may overwrite,
// and which latency class the opcode belongs to.
module alu_flag_mask
  import alu_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic       cy_we_o,
  output logic       ac_we_o,
  output logic       ov_we_o,
  output lat_class_e lat_class_o
);

  flag_we_t mask;

  assign mask    = flag_mask(opcode_i);
  assign cy_we_o = mask.cy_we;
  assign ac_we_o = mask.ac_we;
  assign ov_we_o = mask.ov_we;

  always_comb begin
    lat_class_o = LAT_BASE;
    case (opcode_i)
      ALU_MUL: lat_class_o = LAT_MUL;
      ALU_DIV: lat_class_o = LAT_DIV;
      default: lat_class_o = LAT_BASE;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU operation at a time between the execute stage and alu_core,
// and owns the CY/AC/OV shadow flags that feed the core's carry inputs.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int ALU_LATENCY = 1,
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_opcode,
  input  logic [7:0] req_src_1,
  input  logic [7:0] req_src_2,
  input  logic       req_bit,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_des_1,
  output logic [7:0] rsp_des_2,
  output logic       rsp_err,
  input  logic       psw_wr,
  input  logic [2:0] psw_wdata,
  output logic       cy,
  output logic       ac,
  output logic       ov,
  output logic [4:0] alu_opcode,
  output logic [7:0] alu_src_1,
  output logic [7:0] alu_src_2,
  output logic       alu_carry,
  output logic       alu_aux_carry,
  output logic       alu_bit,
  input  logic [7:0] alu_des_1,
  input  logic [7:0] alu_des_2,
  input  logic       alu_cy,
  input  logic       alu_ac,
  input  logic       alu_ov
);

  localparam int CNT_W = 8;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic [7:0]       src1_q, src1_d, src2_q, src2_d;
  logic             bit_q, bit_d;
  logic [7:0]       des1_q, des1_d, des2_q, des2_d;
  logic             err_q, err_d;
  logic             cy_q, cy_d, ac_q, ac_d, ov_q, ov_d;

  logic [4:0]       dec_op;
  logic             cy_we, ac_we, ov_we;
  lat_class_e       lat_class;
  logic             capture;

  // In IDLE the decoder looks at the incoming request to pick the latency;
  // afterwards it decodes the held opcode for the writeback mask.
  assign dec_op = (state_q == ST_IDLE) ? req_opcode : op_q;

  alu_flag_mask u_flag_mask (
    .opcode_i    (dec_op),
    .cy_we_o     (cy_we),
    .ac_we_o     (ac_we),
    .ov_we_o     (ov_we),
    .lat_class_o (lat_class)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    bit_d   = bit_q;
    des1_d  = des1_q;
    des2_d  = des2_q;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_opcode < ALU_OP_LIMIT) begin
            op_d    = req_opcode;
            src1_d  = req_src_1;
            src2_d  = req_src_2;
            bit_d   = req_bit;
            state_d = ST_EXEC;
            case (lat_class)
              LAT_MUL: cnt_d = CNT_W'(ALU_LATENCY + MUL_CYCLES);
              LAT_DIV: cnt_d = CNT_W'(ALU_LATENCY + DIV_CYCLES);
              default: cnt_d = CNT_W'(ALU_LATENCY);
            endcase
          end else begin
            err_d   = 1'b1;
            des1_d  = 8'h00;
            des2_d  = 8'h00;
            state_d = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          des1_d  = alu_des_1;
          des2_d  = alu_des_2;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An SFR write lands first; a coinciding ALU writeback then overrides only its masked bits.
  always_comb begin
    {cy_d, ac_d, ov_d} = psw_wr ? psw_wdata : {cy_q, ac_q, ov_q};
    if (capture) begin
      if (cy_we) cy_d = alu_cy;
      if (ac_we) ac_d = alu_ac;
      if (ov_we) ov_d = alu_ov;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= ALU_NOP;
      src1_q  <= 8'h00;
      src2_q  <= 8'h00;
      bit_q   <= 1'b0;
      des1_q  <= 8'h00;
      des2_q  <= 8'h00;
      err_q   <= 1'b0;
      cy_q    <= 1'b0;
      ac_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      bit_q   <= bit_d;
      des1_q  <= des1_d;
      des2_q  <= des2_d;
      err_q   <= err_d;
      cy_q    <= cy_d;
      ac_q    <= ac_d;
      ov_q    <= ov_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE) && reset;
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_des_1     = des1_q;
  assign rsp_des_2     = des2_q;
  assign rsp_err       = err_q;
  assign cy            = cy_q;
  assign ac            = ac_q;
  assign ov            = ov_q;
  assign alu_opcode    = (state_q == ST_EXEC) ? op_q : ALU_NOP;
  assign alu_src_1     = src1_q;
  assign alu_src_2     = src2_q;
  assign alu_bit       = bit_q;
  assign alu_carry     = cy_q;
  assign alu_aux_carry = ac_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural alu_core stand-in plus a
// spec-level model of latency, results and PSW flag updates.
module tb_alu_sequencer;

  localparam int ALU_LATENCY = 1;
  localparam int MUL_CYCLES  = 4;
  localparam int DIV_CYCLES  = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [4:0] req_opcode;
  logic [7:0] req_src_1, req_src_2;
  logic       req_bit;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_des_1, rsp_des_2;
  logic       rsp_err;
  logic       psw_wr;
  logic [2:0] psw_wdata;
  logic       cy, ac, ov;
  logic [4:0] alu_opcode;
  logic [7:0] alu_src_1, alu_src_2;
  logic       alu_carry, alu_aux_carry, alu_bit;
  logic [7:0] alu_des_1, alu_des_2;
  logic       alu_cy, alu_ac, alu_ov;

  int checks = 0;
  int errors = 0;
  logic mCy = 1'b0, mAc = 1'b0, mOv = 1'b0;
  logic [18:0] coreOut = '0;

  alu_sequencer #(
    .ALU_LATENCY (ALU_LATENCY),
    .MUL_CYCLES  (MUL_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_src_1(req_src_1), .req_src_2(req_src_2), .req_bit(req_bit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_des_1(rsp_des_1), .rsp_des_2(rsp_des_2), .rsp_err(rsp_err),
    .psw_wr(psw_wr), .psw_wdata(psw_wdata),
    .cy(cy), .ac(ac), .ov(ov),
    .alu_opcode(alu_opcode), .alu_src_1(alu_src_1), .alu_src_2(alu_src_2),
    .alu_carry(alu_carry), .alu_aux_carry(alu_aux_carry), .alu_bit(alu_bit),
    .alu_des_1(alu_des_1), .alu_des_2(alu_des_2),
    .alu_cy(alu_cy), .alu_ac(alu_ac), .alu_ov(alu_ov)
  );

  always #5 clock = ~clock;

  // 8051-style arithmetic, returns {des1, des2, cy, ac, ov}.
  function automatic logic [18:0] aluFunc(input logic [4:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic c,
                                          input logic hc, input logic bt);
    logic [7:0]  d1, d2;
    logic        fc, fa, fo;
    logic [8:0]  s;
    logic [4:0]  h;
    logic [15:0] p;
    d1 = a; d2 = b; fc = c; fa = hc; fo = 1'b0;
    case (op)
      5'h01, 5'h02: begin
        s  = {1'b0, a} + {1'b0, b} + ((op == 5'h02) ? {8'b0, c} : 9'd0);
        h  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + ((op == 5'h02) ? {4'b0, c} : 5'd0);
        d1 = s[7:0]; fc = s[8]; fa = h[4];
        fo = (a[7] == b[7]) && (s[7] != a[7]);
      end
      5'h03: begin
        s  = {1'b0, a} - {1'b0, b} - {8'b0, c};
        h  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, c};
        d1 = s[7:0]; fc = s[8]; fa = h[4];
        fo = (a[7] != b[7]) && (s[7] != a[7]);
      end
      5'h04: d1 = a + 8'd1;
      5'h05: d1 = a - 8'd1;
      5'h06: begin
        p  = {8'b0, a} * {8'b0, b};
        d1 = p[7:0]; d2 = p[15:8]; fc = 1'b0; fo = |p[15:8];
      end
      5'h07: begin
        fc = 1'b0;
        if (b == 8'h00) begin d1 = 8'h00; d2 = 8'h00; fo = 1'b1; end
        else begin d1 = a / b; d2 = a % b; fo = 1'b0; end
      end
      5'h08: begin
        fc = c | (a > 8'h99);
        d1 = a + ((a > 8'h99) ? 8'h60 : 8'h00);
      end
      5'h09: d1 = a & b;
      5'h0A: d1 = a | b;
      5'h0B: d1 = a ^ b;
      5'h0C: fc = 1'b0;
      5'h0D: fc = 1'b1;
      5'h0E: fc = ~c;
      5'h0F: fc = c & bt;
      5'h10: fc = c | bt;
      5'h11: fc = bt;
      default: ;
    endcase
    return {d1, d2, fc, fa, fo};
  endfunction

  // alu_core stand-in with a one-cycle registered output.
  always @(posedge clock)
    coreOut <= aluFunc(alu_opcode, alu_src_1, alu_src_2, alu_carry, alu_aux_carry, alu_bit);
  assign {alu_des_1, alu_des_2, alu_cy, alu_ac, alu_ov} = coreOut;

  function automatic logic [2:0] maskOf(input logic [4:0] op);
    if (op >= 5'h01 && op <= 5'h03) return 3'b111;
    if (op == 5'h06 || op == 5'h07) return 3'b101;
    if (op == 5'h08 || (op >= 5'h0C && op <= 5'h11)) return 3'b100;
    return 3'b000;
  endfunction

  function automatic int latOf(input logic [4:0] op);
    if (op == 5'h06) return ALU_LATENCY + MUL_CYCLES;
    if (op == 5'h07) return ALU_LATENCY + DIV_CYCLES;
    return ALU_LATENCY;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request/response transaction; wrCycle>0 drives psw_wr during that cycle after acceptance.
  task automatic applyStimulus(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic bt, input int hold, input int wrCycle,
                               input logic [2:0] wrData);
    logic        legal;
    int          expN, n;
    logic [18:0] r;
    logic [7:0]  e1, e2;
    logic        eErr;
    logic [2:0]  eFlags, m;
    legal = (op < 5'h12);
    expN  = legal ? latOf(op) + 2 : 1;
    r     = aluFunc(op, a, b, mCy, mAc, bt);
    m     = maskOf(op);
    e1    = legal ? r[18:11] : 8'h00;
    e2    = legal ? r[10:3]  : 8'h00;
    eErr  = ~legal;
    eFlags = (wrCycle > 0 && wrCycle < expN) ? wrData : {mCy, mAc, mOv};
    if (legal) begin
      if (m[2]) eFlags[2] = r[2];
      if (m[1]) eFlags[1] = r[1];
      if (m[0]) eFlags[0] = r[0];
    end

    checkOutput("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_opcode = op; req_src_1 = a; req_src_2 = b; req_bit = bt;
    rsp_ready = 1'b0;
    @(posedge clock);
    #1;
    // Junk on the request port must be ignored until the sequencer is back in IDLE.
    req_opcode = 5'($urandom_range(0, 31));
    req_src_1  = 8'($urandom);
    req_src_2  = 8'($urandom);
    n = 0;
    while (n < 200) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        checkOutput("alu_opcode_exec", {27'b0, alu_opcode}, {27'b0, legal ? op : 5'h00});
        if (legal) checkOutput("alu_src_1_exec", {24'b0, alu_src_1}, {24'b0, a});
      end
      psw_wr    = (n == wrCycle);
      psw_wdata = wrData;
      if (rsp_valid) break;
    end
    psw_wr = 1'b0;
    checkOutput("rsp_latency", n, expN);
    checkOutput("rsp_des_1", {24'b0, rsp_des_1}, {24'b0, e1});
    checkOutput("rsp_des_2", {24'b0, rsp_des_2}, {24'b0, e2});
    checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, eErr});
    checkOutput("flags", {29'b0, cy, ac, ov}, {29'b0, eFlags});
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checkOutput("hold_valid", {31'b0, rsp_valid}, 32'd1);
      checkOutput("hold_des_1", {24'b0, rsp_des_1}, {24'b0, e1});
      checkOutput("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clock);
    checkOutput("back_to_idle", {30'b0, req_ready, rsp_valid}, 32'b10);
    {mCy, mAc, mOv} = eFlags;
  endtask

  task automatic pswWrite(input logic [2:0] d);
    psw_wr = 1'b1; psw_wdata = d;
    @(negedge clock);
    psw_wr = 1'b0;
    {mCy, mAc, mOv} = d;
    checkOutput("psw_write", {29'b0, cy, ac, ov}, {29'b0, d});
  endtask

  initial begin
    logic [4:0] op;
    reset = 1'b0; req_valid = 1'b0; req_opcode = 5'h00; req_src_1 = 8'h00;
    req_src_2 = 8'h00; req_bit = 1'b0; rsp_ready = 1'b0; psw_wr = 1'b0; psw_wdata = 3'b000;
    repeat (2) @(negedge clock);
    checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("reset_rsp", {29'b0, rsp_valid, rsp_err, 1'b0}, 32'd0);
    checkOutput("reset_des", {16'b0, rsp_des_1, rsp_des_2}, 32'd0);
    checkOutput("reset_flags", {29'b0, cy, ac, ov}, 32'd0);
    checkOutput("reset_alu", {14'b0, alu_opcode, alu_src_1, alu_src_2, alu_bit}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("ready_after_reset", {31'b0, req_ready}, 32'd1);

    applyStimulus(5'h01, 8'h40, 8'h20, 1'b0, 0, 0, 3'b000);
    applyStimulus(5'h06, 8'h10, 8'h20, 1'b0, 0, 0, 3'b000);
    applyStimulus(5'h12, 8'h55, 8'hAA, 1'b1, 0, 0, 3'b000);
    applyStimulus(5'h01, 8'h01, 8'h02, 1'b0, 5, 0, 3'b000);
    applyStimulus(5'h02, 8'h00, 8'h00, 1'b0, 0, ALU_LATENCY + 1, 3'b111);
    applyStimulus(5'h09, 8'h0F, 8'hF0, 1'b0, 0, ALU_LATENCY + 1, 3'b111);

    req_valid = 1'b1; req_opcode = 5'h07; req_src_1 = 8'hC8; req_src_2 = 8'h07;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("midreset_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
    checkOutput("midreset_req_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("midreset_flags", {29'b0, cy, ac, ov}, 32'd0);
    checkOutput("midreset_alu", {14'b0, alu_opcode, alu_src_1, alu_src_2, alu_bit}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    {mCy, mAc, mOv} = 3'b000;
    @(negedge clock);
    applyStimulus(5'h01, 8'h7F, 8'h01, 1'b0, 0, 0, 3'b000);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 4) == 0) op = 5'($urandom_range(18, 31));
      else op = 5'($urandom_range(0, 17));
      if ($urandom_range(0, 3) == 0) pswWrite(3'($urandom));
      applyStimulus(op, 8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 2),
                    ($urandom_range(0, 2) == 0) ? latOf(op) + 1 : 0, 3'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
